// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: front-end timing stage of the UART receiver.
// Synchronises RX_IN, runs the 8x-oversampling edge/bit counters and
// majority-votes each bit from the three mid-bit oversamples (phases 3, 4, 5).
module uart_rx_sampler #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BIT_MAX     = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       Enable,
  output logic       SData,
  output logic       SampleValid,
  output logic       BitTick,
  output logic [2:0] EdgeCounter,
  output logic [3:0] BitCounter
);

  localparam int unsigned EDGE_W = 3;
  localparam int unsigned BIT_W  = 4;

  localparam logic [EDGE_W-1:0] EDGE_S3   = EDGE_W'(3);
  localparam logic [EDGE_W-1:0] EDGE_S4   = EDGE_W'(4);
  localparam logic [EDGE_W-1:0] EDGE_VOTE = EDGE_W'(5);
  localparam logic [EDGE_W-1:0] EDGE_PRE  = EDGE_W'(6);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(7);
  localparam logic [BIT_W-1:0]  BIT_SAT   = BIT_W'(BIT_MAX);

  logic [SYNC_STAGES-1:0] syncReg;
  logic                   rxSync;
  logic                   s3;
  logic                   s4;
  logic                   vote;
  logic                   edgeLast;
  logic                   bitSat;

  assign rxSync   = syncReg[SYNC_STAGES-1];
  assign vote     = (s3 & s4) | (s3 & rxSync) | (s4 & rxSync);
  assign edgeLast = (EdgeCounter == EDGE_LAST);
  assign bitSat   = (BitCounter == BIT_SAT);

  // Metastability chain on the raw line; idle level (1) on reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      syncReg <= '1;
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], RX_IN};
    end
  end

  // Oversample phase counter and saturating bit index; both clear while disabled.
  always_ff @(posedge CLK) begin
    if (RST || !Enable) begin
      EdgeCounter <= '0;
      BitCounter  <= '0;
    end else begin
      EdgeCounter <= EdgeCounter + EDGE_W'(1);
      if (edgeLast && !bitSat) begin
        BitCounter <= BitCounter + BIT_W'(1);
      end
    end
  end

  // Mid-bit capture and vote; passthrough of the synchronised line while disabled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      SData       <= 1'b1;
      SampleValid <= 1'b0;
      s3          <= 1'b1;
      s4          <= 1'b1;
    end else if (!Enable) begin
      SData       <= rxSync;
      SampleValid <= 1'b0;
      s3          <= 1'b1;
      s4          <= 1'b1;
    end else begin
      SampleValid <= 1'b0;
      case (EdgeCounter)
        EDGE_S3:   s3 <= rxSync;
        EDGE_S4:   s4 <= rxSync;
        EDGE_VOTE: begin
          SData       <= vote;
          SampleValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // End-of-bit pulse, registered so it coincides with EdgeCounter == 7.
  always_ff @(posedge CLK) begin
    if (RST) begin
      BitTick <= 1'b0;
    end else begin
      BitTick <= Enable && (EdgeCounter == EDGE_PRE);
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Testbench for uart_rx_sampler: vector table for reset/enable/passthrough,
// scoreboard-checked frames, and hand sequences for saturation, abort and reset.
module tb_uart_rx_sampler;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       Enable;
  logic       SData;
  logic       SampleValid;
  logic       BitTick;
  logic [2:0] EdgeCounter;
  logic [3:0] BitCounter;

  int nTests = 0;
  int nFail  = 0;
  int svCnt;
  int tickIdx;
  logic curExp;
  logic expQ[$];

  typedef struct {
    logic       rst;
    logic       rx;
    logic       en;
    logic       sd;
    logic       sv;
    logic       tk;
    logic [2:0] ec;
    logic [3:0] bc;
  } vec_t;

  vec_t vecs[15];

  uart_rx_sampler #(.SYNC_STAGES(2), .BIT_MAX(15)) dut (
    .CLK(CLK),
    .RST(RST),
    .RX_IN(RX_IN),
    .Enable(Enable),
    .SData(SData),
    .SampleValid(SampleValid),
    .BitTick(BitTick),
    .EdgeCounter(EdgeCounter),
    .BitCounter(BitCounter)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Absolute time bound so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    RST    = 1'b0;
    Enable = 1'b0;
    RX_IN  = 1'b1;
    repeat (n) tick();
  endtask

  // Drives a 10-bit frame (bit0 = start) with Enable raised 2 cycles after the
  // start edge so phases 3..5 sample RX_IN indices 3..5 of each bit.
  task automatic run_frame(input string tag, input logic [9:0] bits,
                           input int gStart, input int gLen, input logic [9:0] expBits);
    logic v;
    svCnt   = 0;
    tickIdx = 0;
    curExp  = 1'b1;
    expQ.delete();
    for (int k = 0; k < 88; k++) begin
      RX_IN = (k < 80) ? bits[k/8] : 1'b1;
      if (k >= gStart && k < gStart + gLen) RX_IN = 1'b0;
      Enable = (k >= 2 && k < 82);
      if (k < 80 && (k % 8) == 0) expQ.push_back(expBits[k/8]);
      tick();
      if (SampleValid) begin
        chk({tag, " sv_phase"}, 32'(EdgeCounter), 32'd6);
        if (expQ.size() == 0) begin
          nTests++;
          nFail++;
          $display("FAIL %s sv_extra: got SampleValid=1, expected no pulse", tag);
        end else begin
          v      = expQ.pop_front();
          curExp = v;
          chk({tag, " vote"}, 32'(SData), 32'(v));
        end
        svCnt++;
      end
      if (EdgeCounter == 3'd7) chk({tag, " hold_e7"}, 32'(SData), 32'(curExp));
      if (BitTick) begin
        chk({tag, " tick_bit"}, 32'(BitCounter), 32'(tickIdx));
        tickIdx++;
      end
    end
    chk({tag, " sv_count"}, 32'(svCnt), 32'd10);
    chk({tag, " tick_count"}, 32'(tickIdx), 32'd10);
    chk({tag, " queue_drained"}, 32'(expQ.size()), 32'd0);
    idle(4);
  endtask

  initial begin
    RST    = 1'b1;
    RX_IN  = 1'b0;
    Enable = 1'b1;

    //            rst   rx    en    sd    sv    tk    ec    bc
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 4'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 4'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 4'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};

    // Reset, reset-over-enable, first count and passthrough latency.
    for (int i = 0; i < 15; i++) begin
      RST    = vecs[i].rst;
      RX_IN  = vecs[i].rx;
      Enable = vecs[i].en;
      tick();
      chk($sformatf("vec%0d SData", i), 32'(SData), 32'(vecs[i].sd));
      chk($sformatf("vec%0d SampleValid", i), 32'(SampleValid), 32'(vecs[i].sv));
      chk($sformatf("vec%0d BitTick", i), 32'(BitTick), 32'(vecs[i].tk));
      chk($sformatf("vec%0d EdgeCounter", i), 32'(EdgeCounter), 32'(vecs[i].ec));
      chk($sformatf("vec%0d BitCounter", i), 32'(BitCounter), 32'(vecs[i].bc));
    end
    idle(4);

    // Clean 8N1 frame 0xA5, then single- and double-cycle glitches on data bit 1.
    run_frame("clean", {1'b1, 8'hA5, 1'b0}, -1, 0, {1'b1, 8'hA5, 1'b0});
    run_frame("glitch1", {1'b1, 8'hA5, 1'b0}, 12, 1, {1'b1, 8'hA5, 1'b0});
    run_frame("glitch2", {1'b1, 8'hA5, 1'b0}, 11, 2, {1'b1, 8'hA4, 1'b0});

    // Saturation: 20 bit periods with Enable held.
    Enable = 1'b1;
    for (int j = 1; j <= 160; j++) begin
      tick();
      chk($sformatf("sat%0d EdgeCounter", j), 32'(EdgeCounter), 32'(j % 8));
      chk($sformatf("sat%0d BitCounter", j), 32'(BitCounter),
          32'(((j / 8) > 15) ? 15 : (j / 8)));
      chk($sformatf("sat%0d BitTick", j), 32'(BitTick), 32'((j % 8) == 7));
    end
    idle(4);

    // Enable abort at EdgeCounter 4, BitCounter 3, then passthrough latency.
    Enable = 1'b1;
    repeat (28) tick();
    chk("abort pre EdgeCounter", 32'(EdgeCounter), 32'd4);
    chk("abort pre BitCounter", 32'(BitCounter), 32'd3);
    Enable = 1'b0;
    tick();
    chk("abort EdgeCounter", 32'(EdgeCounter), 32'd0);
    chk("abort BitCounter", 32'(BitCounter), 32'd0);
    chk("abort SampleValid", 32'(SampleValid), 32'd0);
    RX_IN = 1'b0;
    tick();
    chk("abort pt1 SData", 32'(SData), 32'd1);
    chk("abort pt1 SampleValid", 32'(SampleValid), 32'd0);
    tick();
    chk("abort pt2 SData", 32'(SData), 32'd1);
    tick();
    chk("abort pt3 SData", 32'(SData), 32'd0);
    idle(4);

    // Enable reasserted one cycle after deassert restarts from 0.
    Enable = 1'b1;
    repeat (5) tick();
    chk("reen pre EdgeCounter", 32'(EdgeCounter), 32'd5);
    Enable = 1'b0;
    tick();
    chk("reen drop EdgeCounter", 32'(EdgeCounter), 32'd0);
    Enable = 1'b1;
    tick();
    chk("reen EdgeCounter", 32'(EdgeCounter), 32'd1);
    chk("reen BitCounter", 32'(BitCounter), 32'd0);
    idle(4);

    // Reset mid-frame at BitCounter 5, EdgeCounter 5 with the line held low.
    RX_IN = 1'b0;
    repeat (4) tick();
    chk("rstmid pt SData", 32'(SData), 32'd0);
    Enable = 1'b1;
    repeat (45) tick();
    chk("rstmid pre EdgeCounter", 32'(EdgeCounter), 32'd5);
    chk("rstmid pre BitCounter", 32'(BitCounter), 32'd5);
    chk("rstmid pre SData", 32'(SData), 32'd0);
    RST = 1'b1;
    tick();
    chk("rstmid SampleValid", 32'(SampleValid), 32'd0);
    chk("rstmid SData", 32'(SData), 32'd1);
    chk("rstmid EdgeCounter", 32'(EdgeCounter), 32'd0);
    chk("rstmid BitCounter", 32'(BitCounter), 32'd0);
    chk("rstmid BitTick", 32'(BitTick), 32'd0);
    RST = 1'b0;
    tick();
    chk("rstmid post SampleValid", 32'(SampleValid), 32'd0);
    chk("rstmid post BitTick", 32'(BitTick), 32'd0);
    chk("rstmid post EdgeCounter", 32'(EdgeCounter), 32'd1);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
